cmp_serial: RTL and testbench

Bit-serial magnitude comparator that takes two WIDTH-bit operands one bit pair per accepted beat. It produces eq/gt/lt once all WIDTH bits have arrived. It is the serial counterpart of the team's parallel 8-bit comparator and is used where operands arrive over serial links instead of parallel buses. The first differing bit, in significance order, decides the result.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_serial.sv | 135 +++++++++++++
 tb/tb_cmp_serial.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
//   cmp_state_t    : FSM states (IDLE, SHIFT, DONE)
//   CMP_W_DEFAULT  : default operand width
//   cmp_cnt_w()    : bit-counter width needed to count 0..WIDTH
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

    localparam int CMP_W_DEFAULT = 8;

    function automatic int cmp_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cmp_serial.sv
// Bit-serial unsigned magnitude comparator.
// Accepts one (a_bit, b_bit) pair per beat while busy; after WIDTH beats it
// pulses done for one cycle and presents eq/gt/lt, which are held until the
// next completed comparison or reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a new comparison (aborts any in progress)
//   bit_valid  in   a_bit/b_bit valid this cycle (only sampled in SHIFT)
//   a_bit      in   current bit of operand a
//   b_bit      in   current bit of operand b
//   busy       out  accepting bits
//   done       out  one-cycle completion pulse
//   eq/gt/lt   out  held comparison result
//
// Build option: CMP_SERIAL_LSB_FIRST_EN -- operands arrive LSB-first and the
// last differing bit decides; otherwise MSB-first and the first one decides.
module cmp_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = cmp_cnt_w(WIDTH);

    cmp_state_t     r_state;
    cmp_state_t     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic           r_decided;
    logic           r_gt_bit;
    logic           r_lt_bit;
    logic           r_eq;
    logic           r_gt;
    logic           r_lt;

    logic           w_acc;
    logic           w_last;
    logic           w_diff;
    logic           w_take;
    logic           w_dec_n;
    logic           w_gt_n;
    logic           w_lt_n;

    // start wins over a beat presented in the same cycle: that pair is dropped.
    assign w_acc  = (r_state == SHIFT) && bit_valid && !start;
    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_diff = a_bit ^ b_bit;

`ifdef CMP_SERIAL_LSB_FIRST_EN
    // Later bits are more significant, so every difference overwrites.
    assign w_take = w_acc && w_diff;
`else
    // Earlier bits are more significant, so only the first difference counts.
    assign w_take = w_acc && w_diff && !r_decided;
`endif

    // Decision including the current beat, so the WIDTH-th bit can still
    // decide the result that is latched on the edge entering DONE.
    assign w_dec_n = r_decided || (w_acc && w_diff);
    assign w_gt_n  = w_take ? a_bit  : r_gt_bit;
    assign w_lt_n  = w_take ? !a_bit : r_lt_bit;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (start)
                    w_state_nxt = SHIFT;
                else if (w_acc && w_last)
                    w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? SHIFT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_gt_bit  <= 1'b0;
            r_lt_bit  <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                // Result outputs are deliberately left alone here.
                r_cnt     <= '0;
                r_decided <= 1'b0;
                r_gt_bit  <= 1'b0;
                r_lt_bit  <= 1'b0;
            end else if (w_acc) begin
                r_cnt     <= r_cnt + CW'(1);
                r_decided <= w_dec_n;
                r_gt_bit  <= w_gt_n;
                r_lt_bit  <= w_lt_n;
                if (w_last) begin
                    r_eq <= !w_dec_n;
                    r_gt <= w_gt_n;
                    r_lt <= w_lt_n;
                end
            end
        end
    end

    assign eq = r_eq;
    assign gt = r_gt;
    assign lt = r_lt;

endmodule

// File: tb/tb_cmp_serial.sv
// Directed bench for cmp_serial (WIDTH=8). Expected {eq,gt,lt} is derived
// from integer comparison of the operands, queued when an operation is
// launched and popped when done is observed. Inputs change and outputs are
// sampled on the falling edge.
module tb_cmp_serial;

    logic clk = 1'b0;
    logic rst_n, start, bit_valid, a_bit, b_bit;
    logic busy, done, eq, gt, lt;

    int ncmp = 0;
    int nerr = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    cmp_serial #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
        .eq(eq), .gt(gt), .lt(lt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
        return {a == b, a > b, a < b};
    endfunction

    function automatic int bit_idx(input int i);
`ifdef CMP_SERIAL_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; // must be ignored
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
    endtask

    // Send n beats (caller already started); optional one-cycle gap between
    // beats. Checks done stays low before the final beat.
    task automatic send_beats(input logic [7:0] a, input logic [7:0] b,
                              input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps && i > first) begin
                bit_valid = 1'b0;
                @(negedge clk);
                chk("no_early_done_gap", {2'b0, done}, 3'b000);
            end
            bit_valid = 1'b1;
            a_bit = a[bit_idx(i)];
            b_bit = b[bit_idx(i)];
            @(negedge clk);
            bit_valid = 1'b0;
            if (i != 7) chk("no_early_done", {2'b0, done}, 3'b000);
        end
    endtask

    // Called in the cycle after the 8th beat: check done pulse and result.
    task automatic finish_op(input string tag);
        logic [2:0] e;
        chk({tag, "_done"}, {1'b0, busy, done}, 3'b001);
        if (exp_q.size() == 0) begin
            ncmp++; nerr++;
            $error("FAIL %s_queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_res"}, {eq, gt, lt}, e);
        end
        @(negedge clk);
        chk({tag, "_after"}, {1'b0, busy, done}, 3'b000);
    endtask

    task automatic full_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input bit gaps);
        exp_q.push_back(model(a, b));
        pulse_start();
        send_beats(a, b, 0, 8, gaps);
        finish_op(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {1'b0, busy, done}, 3'b000);
        chk("reset_res", {eq, gt, lt}, 3'b000);
        rst_n = 1'b1;

        // bit_valid in IDLE ignored
        bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ignore", {1'b0, busy, done}, 3'b000);
        chk("idle_res", {eq, gt, lt}, 3'b000);
        bit_valid = 1'b0;

        full_op("eq_a5", 8'hA5, 8'hA5, 1'b0);
        full_op("gt_80_7f", 8'h80, 8'h7F, 1'b0);
        full_op("lt_12_13", 8'h12, 8'h13, 1'b0);
        full_op("gap_3c_3d", 8'h3C, 8'h3D, 1'b1);
        full_op("gt_ff_00", 8'hFF, 8'h00, 1'b0);

        // Abort after 4 beats, restart; prior result (gt) held until new done.
        pulse_start();
        send_beats(8'hF0, 8'h00, 0, 4, 1'b0);
        chk("abort_hold", {eq, gt, lt}, 3'b010);
        exp_q.push_back(model(8'h01, 8'h02));
        pulse_start();
        chk("restart_busy", {1'b0, busy, done}, 3'b010);
        send_beats(8'h01, 8'h02, 0, 7, 1'b0);
        chk("restart_hold", {eq, gt, lt}, 3'b010);
        send_beats(8'h01, 8'h02, 7, 1, 1'b0);
        finish_op("restart_lt");

        // Reset mid-SHIFT wins over start and bit_valid.
        pulse_start();
        send_beats(8'hAA, 8'h55, 0, 3, 1'b0);
        rst_n = 1'b0; start = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0;
        chk("rst_mid_ctl", {1'b0, busy, done}, 3'b000);
        chk("rst_mid_res", {eq, gt, lt}, 3'b000);
        full_op("gt_55_54", 8'h55, 8'h54, 1'b0);

        // Reset during DONE.
        exp_q.push_back(3'b000);
        pulse_start();
        send_beats(8'h00, 8'h01, 0, 8, 1'b0);
        chk("pre_rst_done", {1'b0, busy, done}, 3'b001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        chk("rst_done_ctl", {1'b0, busy, done}, 3'b000);
        chk("rst_done_res", {eq, gt, lt}, 3'b000);

        // Start issued during DONE goes straight back to SHIFT.
        exp_q.push_back(model(8'h10, 8'h20));
        pulse_start();
        send_beats(8'h10, 8'h20, 0, 8, 1'b0);
        chk("b2b_done", {1'b0, busy, done}, 3'b001);
        chk("b2b_res", {eq, gt, lt}, exp_q.pop_front());
        exp_q.push_back(model(8'h01, 8'h01));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {1'b0, busy, done}, 3'b010);
        send_beats(8'h01, 8'h01, 0, 8, 1'b0);
        finish_op("b2b_eq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
